// File: rtl/register_writeback_pkg.sv
// Shared constants and types for the register-bank writeback path.
package register_writeback_pkg;

    localparam int unsigned NUM_LANES = 16;
    localparam int unsigned NUM_REGS  = 64;
    localparam int unsigned ADDR_W    = $clog2(NUM_REGS);
    localparam int unsigned DATA_W    = 32;

    // One queued write: destination register, lane mask, all lane data
    typedef struct packed {
        logic [ADDR_W-1:0]           addr;
        logic [NUM_LANES-1:0]        mask;
        logic [NUM_LANES*DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

    // The source that gets priority after `s` has been granted
    function automatic wb_src_e other_src(input wb_src_e s);
        return (s == SRC_ALU) ? SRC_MEM : SRC_ALU;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO holding writeback requests for one producer.
// The head is only valid while not empty; a push is never visible at the
// head in the same cycle it is written.
module wb_fifo
    import register_writeback_pkg::*;
#(
    parameter type         T          = wb_req_t,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W     = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  T                 push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output T                 head_o
);

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    T                 mem_q [FIFO_DEPTH];

    logic push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full FIFO refuses pushes even on a popping edge
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/register_writeback.sv
// Writeback arbiter in front of register_bank's single write port.
// Two producer FIFOs (ALU, memory) are drained round-robin, one registered
// lane-masked write per cycle, with a matching scoreboard release pulse.
module register_writeback
    import register_writeback_pkg::*;
#(
    parameter int unsigned  FIFO_DEPTH = 4,
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        alu_valid,
    output logic                        alu_ready,
    input  logic [ADDR_W-1:0]           alu_waddr,
    input  logic [NUM_LANES-1:0]        alu_mask,
    input  logic [NUM_LANES*DATA_W-1:0] alu_wdata,

    input  logic                        mem_valid,
    output logic                        mem_ready,
    input  logic [ADDR_W-1:0]           mem_waddr,
    input  logic [NUM_LANES-1:0]        mem_mask,
    input  logic [NUM_LANES*DATA_W-1:0] mem_wdata,

    output logic [NUM_LANES-1:0]        write_en,
    output logic [ADDR_W-1:0]           waddr,
    output logic [NUM_LANES*DATA_W-1:0] wdata,
    output logic                        wb_valid,
    output logic [ADDR_W-1:0]           wb_addr,
    output logic [CNT_W-1:0]            mem_fifo_count
);

    wb_req_t          alu_in, mem_in, alu_head, mem_head, grant_req;
    logic             alu_full, alu_empty, mem_full, mem_empty;
    logic             alu_pop, mem_pop;
    logic [CNT_W-1:0] alu_count_unused;

    logic             grant_vld;
    wb_src_e          grant_src;
    wb_src_e          prio_q;

    logic [NUM_LANES-1:0]        write_en_q;
    logic [ADDR_W-1:0]           waddr_q;
    logic [NUM_LANES*DATA_W-1:0] wdata_q;
    logic                        wb_valid_q;

    assign alu_in = '{addr: alu_waddr, mask: alu_mask, data: alu_wdata};
    assign mem_in = '{addr: mem_waddr, mask: mem_mask, data: mem_wdata};

    // Readies come from registered occupancy only
    assign alu_ready = !alu_full;
    assign mem_ready = !mem_full;

    wb_fifo #(.T(wb_req_t), .FIFO_DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (alu_valid),
        .push_data_i (alu_in),
        .pop_i       (alu_pop),
        .full_o      (alu_full),
        .empty_o     (alu_empty),
        .count_o     (alu_count_unused),
        .head_o      (alu_head)
    );

    wb_fifo #(.T(wb_req_t), .FIFO_DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (mem_valid),
        .push_data_i (mem_in),
        .pop_i       (mem_pop),
        .full_o      (mem_full),
        .empty_o     (mem_empty),
        .count_o     (mem_fifo_count),
        .head_o      (mem_head)
    );

    // Round-robin pick: contention resolved by prio, otherwise whichever is non-empty
    always_comb begin
        grant_vld = 1'b0;
        grant_src = SRC_ALU;
        if (!alu_empty && !mem_empty) begin
            grant_vld = 1'b1;
            grant_src = prio_q;
        end else if (!mem_empty) begin
            grant_vld = 1'b1;
            grant_src = SRC_MEM;
        end else if (!alu_empty) begin
            grant_vld = 1'b1;
            grant_src = SRC_ALU;
        end
    end

    assign grant_req = (grant_src == SRC_MEM) ? mem_head : alu_head;
    assign alu_pop   = grant_vld && (grant_src == SRC_ALU);
    assign mem_pop   = grant_vld && (grant_src == SRC_MEM);

    // Output register and priority pointer; address/data hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_en_q <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wb_valid_q <= 1'b0;
            prio_q     <= SRC_MEM;
        end else begin
            wb_valid_q <= grant_vld;
            if (grant_vld) begin
                write_en_q <= grant_req.mask;
                waddr_q    <= grant_req.addr;
                wdata_q    <= grant_req.data;
                prio_q     <= other_src(grant_src);
            end else begin
                write_en_q <= '0;
            end
        end
    end

    assign write_en = write_en_q;
    assign waddr    = waddr_q;
    assign wb_addr  = waddr_q;
    assign wdata    = wdata_q;
    assign wb_valid = wb_valid_q;

endmodule

// File: tb/tb_register_writeback.sv
// Bench for register_writeback: reset checks, a directed vector table,
// round-robin / backpressure streams, mid-operation reset, and a random
// run compared against a queue-based reference model.
module tb_register_writeback;
    import register_writeback_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WD    = NUM_LANES * DATA_W;

    logic                 clk, rst_n;
    logic                 alu_valid, alu_ready, mem_valid, mem_ready;
    logic [ADDR_W-1:0]    alu_waddr, mem_waddr, waddr, wb_addr;
    logic [NUM_LANES-1:0] alu_mask, mem_mask, write_en;
    logic [WD-1:0]        alu_wdata, mem_wdata, wdata;
    logic                 wb_valid;
    logic [2:0]           mem_fifo_count;

    register_writeback #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_waddr      (alu_waddr),
        .alu_mask       (alu_mask),
        .alu_wdata      (alu_wdata),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_waddr      (mem_waddr),
        .mem_mask       (mem_mask),
        .mem_wdata      (mem_wdata),
        .write_en       (write_en),
        .waddr          (waddr),
        .wdata          (wdata),
        .wb_valid       (wb_valid),
        .wb_addr        (wb_addr),
        .mem_fifo_count (mem_fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [WD-1:0] act, input logic [WD-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: two queues plus a priority bit ----------------
    wb_req_t              qa[$], qm[$];
    logic                 prio_mem;
    logic                 e_vld;
    logic [NUM_LANES-1:0] e_we;
    logic [ADDR_W-1:0]    e_addr;
    logic [WD-1:0]        e_data;

    task automatic model_reset();
        qa.delete();
        qm.delete();
        prio_mem = 1'b1;
        e_vld = 1'b0;
        e_we = '0;
        e_addr = '0;
        e_data = '0;
    endtask

    function automatic logic [WD-1:0] data_for(input logic [ADDR_W-1:0] a);
        logic [WD-1:0] d;
        for (int i = 0; i < NUM_LANES; i++)
            d[DATA_W*i +: DATA_W] = 32'hA000_0000 + (32'(a) << 16) + 32'(i);
        return d;
    endfunction

    function automatic wb_req_t rand_req();
        wb_req_t r;
        r.addr = ADDR_W'($urandom);
        r.mask = NUM_LANES'($urandom);
        for (int i = 0; i < NUM_LANES; i++) r.data[DATA_W*i +: DATA_W] = $urandom;
        return r;
    endfunction

    // One clock: drive requests, check readies, advance model, check outputs after the edge
    task automatic step(input logic av, input wb_req_t ar, input logic mv, input wb_req_t mr,
                        output logic a_acc, output logic m_acc);
        wb_req_t r;
        logic    use_mem;
        alu_valid = av; alu_waddr = ar.addr; alu_mask = ar.mask; alu_wdata = ar.data;
        mem_valid = mv; mem_waddr = mr.addr; mem_mask = mr.mask; mem_wdata = mr.data;
        #1;
        chk("alu_ready", WD'(alu_ready), WD'(qa.size() != DEPTH));
        chk("mem_ready", WD'(mem_ready), WD'(qm.size() != DEPTH));
        a_acc = av && (qa.size() != DEPTH);
        m_acc = mv && (qm.size() != DEPTH);
        if (qa.size() != 0 || qm.size() != 0) begin
            use_mem  = (qm.size() != 0) && ((qa.size() == 0) || prio_mem);
            r        = use_mem ? qm.pop_front() : qa.pop_front();
            prio_mem = !use_mem;
            e_vld = 1'b1; e_we = r.mask; e_addr = r.addr; e_data = r.data;
        end else begin
            e_vld = 1'b0; e_we = '0;
        end
        if (a_acc) qa.push_back(ar);
        if (m_acc) qm.push_back(mr);
        @(posedge clk); #1;
        chk("wb_valid", WD'(wb_valid), WD'(e_vld));
        chk("write_en", WD'(write_en), WD'(e_we));
        chk("waddr", WD'(waddr), WD'(e_addr));
        chk("wb_addr", WD'(wb_addr), WD'(e_addr));
        chk("wdata", wdata, e_data);
        chk("mem_fifo_count", WD'(mem_fifo_count), WD'(qm.size()));
    endtask

    task automatic idle(input int n);
        logic x, y;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, x, y);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_write_en"}, WD'(write_en), '0);
        chk({tag, "_wb_valid"}, WD'(wb_valid), '0);
        chk({tag, "_waddr"}, WD'(waddr), '0);
        chk({tag, "_wb_addr"}, WD'(wb_addr), '0);
        chk({tag, "_wdata"}, wdata, '0);
        chk({tag, "_mem_cnt"}, WD'(mem_fifo_count), '0);
        chk({tag, "_alu_ready"}, WD'(alu_ready), WD'(1));
        chk({tag, "_mem_ready"}, WD'(mem_ready), WD'(1));
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        alu_valid = 1'b0; mem_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Producer streams with valid held until accepted; records emitted addresses
    logic [ADDR_W-1:0] emitted[$];
    logic              saw_a_full, saw_m_full;

    task automatic stream(input int na, input int nm, input logic [ADDR_W-1:0] ba,
                          input logic [ADDR_W-1:0] bm);
        int      ia, im, cyc;
        logic    aa, ma;
        wb_req_t ra, rm;
        ia = 0; im = 0; cyc = 0;
        emitted.delete();
        saw_a_full = 1'b0; saw_m_full = 1'b0;
        while ((ia < na || im < nm || qa.size() != 0 || qm.size() != 0) && cyc < 200) begin
            ra.addr = ba + ADDR_W'(ia); ra.mask = '1; ra.data = data_for(ra.addr);
            rm.addr = bm + ADDR_W'(im); rm.mask = '1; rm.data = data_for(rm.addr);
            step(ia < na, ra, im < nm, rm, aa, ma);
            if (aa) ia++;
            if (ma) im++;
            if (!alu_ready) saw_a_full = 1'b1;
            if (!mem_ready) saw_m_full = 1'b1;
            if (wb_valid) emitted.push_back(waddr);
            cyc++;
        end
        chk("stream_budget", WD'(cyc < 200), WD'(1));
    endtask

    // Directed vector table
    typedef struct {
        logic                 av;
        logic [ADDR_W-1:0]    aa;
        logic [NUM_LANES-1:0] am;
        logic                 mv;
        logic [ADDR_W-1:0]    ma;
        logic [NUM_LANES-1:0] mm;
        logic                 x_vld;
        logic [NUM_LANES-1:0] x_we;
        logic [ADDR_W-1:0]    x_addr;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic              x, y;
        logic [WD-1:0]     last_d, exp_d;
        logic [ADDR_W-1:0] exp_a;
        wb_req_t           ra, rm;
        int                ai, mi;

        tbl[0]  = '{1'b1, 6'h05, 16'hFFFF, 1'b0, 6'h00, 16'h0000, 1'b0, 16'h0000, 6'h00};
        tbl[1]  = '{1'b0, 6'h00, 16'h0000, 1'b0, 6'h00, 16'h0000, 1'b1, 16'hFFFF, 6'h05};
        tbl[2]  = '{1'b0, 6'h00, 16'h0000, 1'b1, 6'h3F, 16'h00F0, 1'b0, 16'h0000, 6'h05};
        tbl[3]  = '{1'b0, 6'h00, 16'h0000, 1'b0, 6'h00, 16'h0000, 1'b1, 16'h00F0, 6'h3F};
        tbl[4]  = '{1'b1, 6'h0A, 16'h0000, 1'b0, 6'h00, 16'h0000, 1'b0, 16'h0000, 6'h3F};
        tbl[5]  = '{1'b0, 6'h00, 16'h0000, 1'b0, 6'h00, 16'h0000, 1'b1, 16'h0000, 6'h0A};
        tbl[6]  = '{1'b0, 6'h00, 16'h0000, 1'b0, 6'h00, 16'h0000, 1'b0, 16'h0000, 6'h0A};
        tbl[7]  = '{1'b1, 6'h11, 16'h000F, 1'b1, 6'h22, 16'hF000, 1'b0, 16'h0000, 6'h0A};
        tbl[8]  = '{1'b0, 6'h00, 16'h0000, 1'b0, 6'h00, 16'h0000, 1'b1, 16'hF000, 6'h22};
        tbl[9]  = '{1'b0, 6'h00, 16'h0000, 1'b0, 6'h00, 16'h0000, 1'b1, 16'h000F, 6'h11};
        tbl[10] = '{1'b0, 6'h00, 16'h0000, 1'b0, 6'h00, 16'h0000, 1'b0, 16'h0000, 6'h11};

        // ---- reset held with both producers requesting ----
        rst_n = 1'b1;
        alu_valid = 1'b1; alu_waddr = 6'h01; alu_mask = '1; alu_wdata = data_for(6'h01);
        mem_valid = 1'b1; mem_waddr = 6'h21; mem_mask = '1; mem_wdata = data_for(6'h21);
        #1 rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check_zero_outputs("in_reset");
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        rst_n = 1'b1;
        idle(3);

        // ---- directed table ----
        last_d = '0;
        for (int r = 0; r < 11; r++) begin
            ra.addr = tbl[r].aa; ra.mask = tbl[r].am; ra.data = data_for(tbl[r].aa);
            rm.addr = tbl[r].ma; rm.mask = tbl[r].mm; rm.data = data_for(tbl[r].ma);
            step(tbl[r].av, ra, tbl[r].mv, rm, x, y);
            exp_d = tbl[r].x_vld ? data_for(tbl[r].x_addr) : last_d;
            chk($sformatf("tbl%0d_vld", r), WD'(wb_valid), WD'(tbl[r].x_vld));
            chk($sformatf("tbl%0d_we", r), WD'(write_en), WD'(tbl[r].x_we));
            chk($sformatf("tbl%0d_addr", r), WD'(waddr), WD'(tbl[r].x_addr));
            chk($sformatf("tbl%0d_data", r), wdata, exp_d);
            last_d = exp_d;
        end

        // ---- round-robin: ALU 0..7, MEM 32..39, from reset priority ----
        do_reset();
        stream(8, 8, 6'd0, 6'd32);
        chk("rr_count", WD'(emitted.size()), WD'(16));
        for (int k = 0; k < 16; k++) begin
            exp_a = (k % 2 == 0) ? ADDR_W'(32 + k / 2) : ADDR_W'(k / 2);
            chk($sformatf("rr_order%0d", k), WD'(emitted.size() > k ? emitted[k] : 'x), WD'(exp_a));
        end

        // ---- backpressure: 12 per source, readies must drop and recover ----
        stream(12, 12, 6'h00, 6'h20);
        chk("bp_count", WD'(emitted.size()), WD'(24));
        chk("bp_alu_full_seen", WD'(saw_a_full), WD'(1));
        chk("bp_mem_full_seen", WD'(saw_m_full), WD'(1));
        ai = 0; mi = 0;
        foreach (emitted[k]) begin
            if (emitted[k] >= 6'h20) begin
                chk("bp_mem_order", WD'(emitted[k]), WD'(6'h20 + ADDR_W'(mi)));
                mi++;
            end else begin
                chk("bp_alu_order", WD'(emitted[k]), WD'(ADDR_W'(ai)));
                ai++;
            end
        end
        chk("bp_alu_total", WD'(ai), WD'(12));
        chk("bp_mem_total", WD'(mi), WD'(12));

        // ---- reset mid-operation with entries queued ----
        ra.addr = 6'h01; ra.mask = '1; ra.data = data_for(6'h01);
        rm.addr = 6'h21; rm.mask = '1; rm.data = data_for(6'h21);
        step(1'b1, ra, 1'b1, rm, x, y);
        ra.addr = 6'h02; rm.addr = 6'h22;
        step(1'b1, ra, 1'b1, rm, x, y);
        rm.addr = 6'h23;
        step(1'b0, ra, 1'b1, rm, x, y);
        chk("pre_reset_active", WD'(wb_valid), WD'(1));
        #3;
        rst_n = 1'b0;
        alu_valid = 1'b0; mem_valid = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        idle(4);

        // ---- random traffic against the model ----
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 99) < 60, rand_req(), $urandom_range(0, 99) < 60, rand_req(), x, y);
        end
        idle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
